// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction field positions, widths and
// the fetch-unit state encoding.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_J    = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_JAL  = 4'd11;
    localparam logic [3:0] OP_AND  = 4'd12;
    localparam logic [3:0] OP_OR   = 4'd13;
    localparam logic [3:0] OP_SRL  = 4'd14;
    localparam logic [3:0] OP_JR   = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } ifu_state_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory read port and the opcode handshake toward the
// control unit; master is the fetch unit, slave is memory plus control unit.
interface instr_fetch_unit_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd_req;
    logic               mem_rd_ack;
    logic [INSTR_W-1:0] mem_rd_data;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         Opcode;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_value;
    logic               fetch_err;

    modport master (
        output mem_addr, mem_rd_req,
        input  mem_rd_ack, mem_rd_data,
        output ir, Opcode, instr_pc, instr_valid,
        input  instr_ready, pc_load, pc_load_value,
        output fetch_err
    );

    modport slave (
        input  mem_addr, mem_rd_req,
        output mem_rd_ack, mem_rd_data,
        input  ir, Opcode, instr_pc, instr_valid,
        output instr_ready, pc_load, pc_load_value,
        input  fetch_err
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, instruction register and IDLE/FETCH/VALID FSM.
// Optional fetch watchdog enabled by defining IFU_FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter logic [ADDR_W-1:0] PC_INC   = 16'd2
`ifdef IFU_FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
    input  logic CLK,
    input  logic Reset,
    instr_fetch_unit_if.master bus
);

    ifu_state_t         state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next;
    logic [INSTR_W-1:0] ir_q, ir_next;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_next;
    logic               timeout_hit;
    logic               halted;

`ifdef IFU_FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       err_q;

    // The final no-ack FETCH cycle trips the watchdog; an ack in that cycle wins.
    assign timeout_hit = (state == FETCH) && !bus.mem_rd_ack &&
                         (wait_cnt == 4'(TIMEOUT_CYCLES - 1));
    assign halted      = err_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            if (state != FETCH) begin
                wait_cnt <= 4'd0;
            end else if (!bus.mem_rd_ack) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign halted      = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir_q       <= '0;
            instr_pc_q <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ir_q       <= ir_next;
            instr_pc_q <= instr_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        ir_next       = ir_q;
        instr_pc_next = instr_pc_q;
        case (state)
            IDLE: begin
                if (!halted) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (bus.mem_rd_ack) begin
                    ir_next       = bus.mem_rd_data;
                    instr_pc_next = pc;
                    pc_next       = pc + PC_INC;
                    state_next    = VALID;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            VALID: begin
                // Redirects are only honoured when the instruction is consumed.
                if (bus.instr_ready) begin
                    if (bus.pc_load) begin
                        pc_next = bus.pc_load_value;
                    end
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_addr    = pc;
    assign bus.mem_rd_req  = (state == FETCH);
    assign bus.instr_valid = (state == VALID);
    assign bus.ir          = ir_q;
    assign bus.Opcode      = opcode_of(ir_q);
    assign bus.instr_pc    = instr_pc_q;
    assign bus.fetch_err   = halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; a second instance with
// RESET_PC=FFFC exercises PC wrap-around.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic CLK = 1'b0;
    logic Reset = 1'b0;
    int checks = 0;
    int fails = 0;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if wbus ();

    instr_fetch_unit #(.RESET_PC(16'h0000), .PC_INC(16'd2)) dut (
        .CLK(CLK), .Reset(Reset), .bus(bus)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFC), .PC_INC(16'd2)) dut_wrap (
        .CLK(CLK), .Reset(Reset), .bus(wbus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_rd_ack = 1'b0; bus.mem_rd_data = 16'h0000;
        bus.instr_ready = 1'b0; bus.pc_load = 1'b0; bus.pc_load_value = 16'h0000;
        wbus.mem_rd_ack = 1'b0; wbus.mem_rd_data = 16'h0000;
        wbus.instr_ready = 1'b0; wbus.pc_load = 1'b0; wbus.pc_load_value = 16'h0000;
        do_reset();
        checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid actual=%0b required=0", bus.instr_valid); end
        checks++; if (bus.mem_rd_req !== 1'b0) begin fails++; $display("FAIL rst_req actual=%0b required=0", bus.mem_rd_req); end
        checks++; if (bus.ir !== 16'h0000) begin fails++; $display("FAIL rst_ir actual=%h required=0000", bus.ir); end
        checks++; if (bus.Opcode !== 4'h0) begin fails++; $display("FAIL rst_opcode actual=%h required=0", bus.Opcode); end
        checks++; if (bus.instr_pc !== 16'h0000) begin fails++; $display("FAIL rst_instr_pc actual=%h required=0000", bus.instr_pc); end
        checks++; if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL rst_addr actual=%h required=0000", bus.mem_addr); end
        checks++; if (bus.fetch_err !== 1'b0) begin fails++; $display("FAIL rst_err actual=%0b required=0", bus.fetch_err); end
        checks++; if (wbus.mem_addr !== 16'hFFFC) begin fails++; $display("FAIL rst_wrap_addr actual=%h required=fffc", wbus.mem_addr); end
    endtask

    // Memory acks immediately; ack held high in IDLE must not capture early.
    task automatic test_immediate_ack();
        bus.mem_rd_ack = 1'b1; bus.mem_rd_data = 16'h2135;
        tick();
        checks++; if (bus.mem_rd_req !== 1'b1) begin fails++; $display("FAIL t1_req actual=%0b required=1", bus.mem_rd_req); end
        checks++; if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL t1_addr actual=%h required=0000", bus.mem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL t1_early_valid actual=%0b required=0", bus.instr_valid); end
        tick();
        bus.mem_rd_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL t1_valid actual=%0b required=1", bus.instr_valid); end
        checks++; if (bus.Opcode !== OP_ADDI) begin fails++; $display("FAIL t1_opcode actual=%h required=2", bus.Opcode); end
        checks++; if (bus.ir !== 16'h2135) begin fails++; $display("FAIL t1_ir actual=%h required=2135", bus.ir); end
        checks++; if (bus.instr_pc !== 16'h0000) begin fails++; $display("FAIL t1_instr_pc actual=%h required=0000", bus.instr_pc); end
        checks++; if (bus.mem_addr !== 16'h0002) begin fails++; $display("FAIL t1_next_addr actual=%h required=0002", bus.mem_addr); end
        checks++; if (bus.mem_rd_req !== 1'b0) begin fails++; $display("FAIL t1_req_in_valid actual=%0b required=0", bus.mem_rd_req); end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL t1_consumed actual=%0b required=0", bus.instr_valid); end
    endtask

    task automatic test_delayed_ack();
        bus.mem_rd_data = 16'h5A3C;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.mem_rd_req !== 1'b1) begin fails++; $display("FAIL t2_req cyc=%0d actual=%0b required=1", i, bus.mem_rd_req); end
            checks++; if (bus.mem_addr !== 16'h0002) begin fails++; $display("FAIL t2_addr cyc=%0d actual=%h required=0002", i, bus.mem_addr); end
            checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL t2_valid_early cyc=%0d actual=%0b required=0", i, bus.instr_valid); end
            if (i == 3) bus.mem_rd_ack = 1'b1;
            tick();
        end
        bus.mem_rd_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL t2_valid actual=%0b required=1", bus.instr_valid); end
        checks++; if (bus.ir !== 16'h5A3C) begin fails++; $display("FAIL t2_ir actual=%h required=5a3c", bus.ir); end
        checks++; if (bus.Opcode !== OP_LW) begin fails++; $display("FAIL t2_opcode actual=%h required=5", bus.Opcode); end
        checks++; if (bus.instr_pc !== 16'h0002) begin fails++; $display("FAIL t2_instr_pc actual=%h required=0002", bus.instr_pc); end
        checks++; if (bus.mem_addr !== 16'h0004) begin fails++; $display("FAIL t2_next_addr actual=%h required=0004", bus.mem_addr); end
    endtask

    // Stall in VALID with stray ack and pc_load but no ready, then redirect.
    task automatic test_hold_and_redirect();
        bus.mem_rd_ack = 1'b1; bus.mem_rd_data = 16'hBEEF;
        bus.pc_load = 1'b1; bus.pc_load_value = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL t3_valid cyc=%0d actual=%0b required=1", i, bus.instr_valid); end
            checks++; if (bus.ir !== 16'h5A3C) begin fails++; $display("FAIL t3_ir cyc=%0d actual=%h required=5a3c", i, bus.ir); end
            checks++; if (bus.Opcode !== 4'h5) begin fails++; $display("FAIL t3_opcode cyc=%0d actual=%h required=5", i, bus.Opcode); end
            checks++; if (bus.mem_rd_req !== 1'b0) begin fails++; $display("FAIL t3_req cyc=%0d actual=%0b required=0", i, bus.mem_rd_req); end
            checks++; if (bus.mem_addr !== 16'h0004) begin fails++; $display("FAIL t3_addr cyc=%0d actual=%h required=0004", i, bus.mem_addr); end
        end
        bus.mem_rd_ack = 1'b0;
        bus.instr_ready = 1'b1; bus.pc_load_value = 16'h0040;
        tick();
        bus.instr_ready = 1'b0; bus.pc_load = 1'b0;
        checks++; if (bus.mem_addr !== 16'h0040) begin fails++; $display("FAIL t3_redirect actual=%h required=0040", bus.mem_addr); end
        checks++; if (bus.mem_rd_req !== 1'b1) begin fails++; $display("FAIL t3_req_after actual=%0b required=1", bus.mem_rd_req); end
    endtask

    task automatic test_back_to_back();
        bus.mem_rd_ack = 1'b1; bus.mem_rd_data = 16'hF000;
        tick();
        bus.mem_rd_ack = 1'b0;
        checks++; if (bus.Opcode !== OP_JR) begin fails++; $display("FAIL t4_opcode actual=%h required=f", bus.Opcode); end
        checks++; if (bus.instr_pc !== 16'h0040) begin fails++; $display("FAIL t4_instr_pc actual=%h required=0040", bus.instr_pc); end
        checks++; if (bus.mem_addr !== 16'h0042) begin fails++; $display("FAIL t4_addr actual=%h required=0042", bus.mem_addr); end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        checks++; if (bus.mem_addr !== 16'h0042) begin fails++; $display("FAIL t4_seq_addr actual=%h required=0042", bus.mem_addr); end
    endtask

    task automatic test_reset_midway();
        // Reset in FETCH with a pending ack: no capture.
        bus.mem_rd_ack = 1'b1; bus.mem_rd_data = 16'hFFFF;
        Reset = 1'b1;
        tick();
        Reset = 1'b0; bus.mem_rd_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL t5_f_valid actual=%0b required=0", bus.instr_valid); end
        checks++; if (bus.mem_rd_req !== 1'b0) begin fails++; $display("FAIL t5_f_req actual=%0b required=0", bus.mem_rd_req); end
        checks++; if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL t5_f_pc actual=%h required=0000", bus.mem_addr); end
        checks++; if (bus.ir !== 16'h0000) begin fails++; $display("FAIL t5_f_ir actual=%h required=0000", bus.ir); end
        tick();
        bus.mem_rd_ack = 1'b1; bus.mem_rd_data = 16'h3111;
        tick();
        bus.mem_rd_ack = 1'b0;
        checks++; if (bus.ir !== 16'h3111) begin fails++; $display("FAIL t5_cap_ir actual=%h required=3111", bus.ir); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL t5_v_valid actual=%0b required=0", bus.instr_valid); end
        checks++; if (bus.mem_rd_req !== 1'b0) begin fails++; $display("FAIL t5_v_req actual=%0b required=0", bus.mem_rd_req); end
        checks++; if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL t5_v_pc actual=%h required=0000", bus.mem_addr); end
        checks++; if (bus.ir !== 16'h0000) begin fails++; $display("FAIL t5_v_ir actual=%h required=0000", bus.ir); end
        bus.mem_rd_ack = 1'b1; bus.mem_rd_data = 16'h7777;
        tick();
        bus.mem_rd_ack = 1'b0;
        checks++; if (bus.ir !== 16'h0000) begin fails++; $display("FAIL t5_idle_ack_ir actual=%h required=0000", bus.ir); end
        checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL t5_idle_ack_valid actual=%0b required=0", bus.instr_valid); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr [5];
        logic [4:0]  exp_req;
        exp_addr[0] = 16'hFFFC; exp_addr[1] = 16'hFFFE; exp_addr[2] = 16'hFFFE;
        exp_addr[3] = 16'h0000; exp_addr[4] = 16'h0000;
        exp_req = 5'b10101;
        do_reset();
        wbus.mem_rd_ack = 1'b1; wbus.instr_ready = 1'b1; wbus.mem_rd_data = 16'h8000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (wbus.mem_addr !== exp_addr[i]) begin fails++; $display("FAIL t6_wrap_addr cyc=%0d actual=%h required=%h", i, wbus.mem_addr, exp_addr[i]); end
            checks++; if (wbus.mem_rd_req !== exp_req[i]) begin fails++; $display("FAIL t6_wrap_req cyc=%0d actual=%0b required=%0b", i, wbus.mem_rd_req, exp_req[i]); end
            if (i == 3) begin
                checks++; if (wbus.instr_pc !== 16'hFFFE) begin fails++; $display("FAIL t6_wrap_instr_pc actual=%h required=fffe", wbus.instr_pc); end
            end
        end
        wbus.mem_rd_ack = 1'b0; wbus.instr_ready = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        bus.mem_rd_ack = 1'b0;
        tick();
`ifdef IFU_FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            checks++; if (bus.mem_rd_req !== 1'b1 || bus.fetch_err !== 1'b0) begin fails++; $display("FAIL t7_wait cyc=%0d actual=req%0b/err%0b required=req1/err0", i, bus.mem_rd_req, bus.fetch_err); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.fetch_err !== 1'b1) begin fails++; $display("FAIL t7_err cyc=%0d actual=%0b required=1", i, bus.fetch_err); end
            checks++; if (bus.mem_rd_req !== 1'b0) begin fails++; $display("FAIL t7_halt_req cyc=%0d actual=%0b required=0", i, bus.mem_rd_req); end
            tick();
        end
        do_reset();
        checks++; if (bus.fetch_err !== 1'b0) begin fails++; $display("FAIL t7_err_cleared actual=%0b required=0", bus.fetch_err); end
        tick();
        bus.mem_rd_data = 16'h7ABC;
        for (int i = 0; i < 15; i++) begin
            if (i == 14) bus.mem_rd_ack = 1'b1;
            tick();
        end
        bus.mem_rd_ack = 1'b0;
        checks++; if (bus.fetch_err !== 1'b0) begin fails++; $display("FAIL t7_late_err actual=%0b required=0", bus.fetch_err); end
        checks++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL t7_late_valid actual=%0b required=1", bus.instr_valid); end
        checks++; if (bus.ir !== 16'h7ABC) begin fails++; $display("FAIL t7_late_ir actual=%h required=7abc", bus.ir); end
`else
        for (int i = 0; i < 20; i++) begin
            checks++; if (bus.mem_rd_req !== 1'b1 || bus.fetch_err !== 1'b0) begin fails++; $display("FAIL t7_nowatchdog cyc=%0d actual=req%0b/err%0b required=req1/err0", i, bus.mem_rd_req, bus.fetch_err); end
            tick();
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        test_reset();
        test_immediate_ack();
        test_delayed_ack();
        test_hold_and_redirect();
        test_back_to_back();
        test_reset_midway();
        test_wrap();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
